dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: the CPU pipeline MEM stage (port 0) and the NN accelerator bus master (port 1).
- Serialises accesses one at a time and applies fixed memory latency.
- CPU has default priority; a starvation counter guarantees forward progress for the accelerator.
- Drives the stall back into the CPU pipeline while a CPU access is outstanding.

---
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage (port 0) and the NN accelerator (port 1).
// One access in flight at a time, fixed memory latency, CPU priority with a starvation escape.
module dmem_arbiter #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic [DATA_W-1:0] acc_rdata,
  output logic              acc_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        r_state, w_state_nxt;
  logic [LAT_W-1:0]  r_lat_cnt, w_lat_nxt;
  logic              r_owner, w_owner_nxt;
  logic [STV_W-1:0]  r_starve, w_starve_nxt;
  logic              r_mem_en, w_mem_en_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [DATA_W-1:0] r_cpu_rdata, w_cpu_rdata_nxt;
  logic [DATA_W-1:0] r_acc_rdata, w_acc_rdata_nxt;
  logic              r_cpu_done, w_cpu_done_nxt;
  logic              r_acc_done, w_acc_done_nxt;
  logic              w_grant_acc;

  // Accelerator wins when alone, or when the CPU has starved it for STARVE_MAX grants.
  assign w_grant_acc = acc_req & (~cpu_req | (r_starve == STV_W'(STARVE_MAX)));

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_lat_nxt       = r_lat_cnt;
    w_owner_nxt     = r_owner;
    w_starve_nxt    = r_starve;
    w_mem_en_nxt    = 1'b0;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_acc_rdata_nxt = r_acc_rdata;
    w_cpu_done_nxt  = 1'b0;
    w_acc_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_req | acc_req) begin
          w_owner_nxt     = w_grant_acc;
          w_mem_en_nxt    = 1'b1;
          w_mem_we_nxt    = w_grant_acc ? acc_we    : cpu_we;
          w_mem_addr_nxt  = w_grant_acc ? acc_addr  : cpu_addr;
          w_mem_wdata_nxt = w_grant_acc ? acc_wdata : cpu_wdata;
          w_lat_nxt       = LAT_W'(MEM_LAT);
          w_state_nxt     = S_ACCESS;
          if (w_grant_acc) begin
            w_starve_nxt = '0;
          end else if (acc_req && (r_starve != STV_W'(STARVE_MAX))) begin
            w_starve_nxt = r_starve + STV_W'(1);
          end
        end
      end
      S_ACCESS: begin
        // Read data is sampled MEM_LAT cycles after the mem_en cycle.
        if (r_lat_cnt == '0) begin
          if (!r_mem_we) begin
            if (r_owner) w_acc_rdata_nxt = mem_rdata;
            else         w_cpu_rdata_nxt = mem_rdata;
          end
          w_cpu_done_nxt = ~r_owner;
          w_acc_done_nxt = r_owner;
          w_state_nxt    = S_DONE;
        end else begin
          w_lat_nxt = r_lat_cnt - LAT_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lat_cnt   <= '0;
      r_owner     <= 1'b0;
      r_starve    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rdata <= '0;
      r_acc_rdata <= '0;
      r_cpu_done  <= 1'b0;
      r_acc_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lat_cnt   <= w_lat_nxt;
      r_owner     <= w_owner_nxt;
      r_starve    <= w_starve_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_acc_rdata <= w_acc_rdata_nxt;
      r_cpu_done  <= w_cpu_done_nxt;
      r_acc_done  <= w_acc_done_nxt;
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_rdata = r_cpu_rdata;
  assign acc_rdata = r_acc_rdata;
  assign cpu_done  = r_cpu_done;
  assign acc_done  = r_acc_done;
  // Stall drops in the done cycle so the pipeline advances exactly once.
  assign cpu_stall = cpu_req & ~r_cpu_done;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (grant order, latency, read data from a reference memory).
module tb_dmem_arbiter;

  localparam int unsigned LAT1 = 1;
  localparam int unsigned LAT3 = 3;
  localparam int unsigned SMAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        cpu_req, cpu_we, acc_req, acc_we;
  logic [15:0] cpu_addr, cpu_wdata, acc_addr, acc_wdata;
  logic [15:0] cpu_rdata, acc_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_done, cpu_stall, acc_done, mem_en, mem_we, busy;

  logic        c3_req, c3_we;
  logic [15:0] c3_addr, c3_wdata;
  logic [15:0] cpu_rdata3, acc_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic        cpu_done3, cpu_stall3, acc_done3, mem_en3, mem_we3, busy3;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(LAT1), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_rdata(acc_rdata), .acc_done(acc_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(LAT3), .STARVE_MAX(SMAX)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
    .cpu_rdata(cpu_rdata3), .cpu_done(cpu_done3), .cpu_stall(cpu_stall3),
    .acc_req(1'b0), .acc_we(1'b0), .acc_addr(16'h0), .acc_wdata(16'h0),
    .acc_rdata(acc_rdata3), .acc_done(acc_done3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Memory environment: data is only valid exactly MEM_LAT cycles after mem_en, junk otherwise.
  function automatic logic [15:0] fill(input logic [7:0] a);
    return {a, ~a};
  endfunction

  logic [15:0]  env1 [256];
  logic [15:0]  env3 [256];
  logic [255:0] vld1 = '0;
  logic [255:0] vld3 = '0;
  logic [7:0]   ea1 = '0, ea3 = '0;
  int           ec1 = 0, ec3 = 0;
  logic [15:0]  junk = 16'h0;
  logic         pre1 = 1'b0, pre3 = 1'b0;
  logic [7:0]   pre_a = '0;
  logic [15:0]  pre_d = '0;

  always @(posedge clk) begin
    junk <= 16'($urandom);
    if (pre1) begin env1[pre_a] <= pre_d; vld1[pre_a] <= 1'b1; end
    if (pre3) begin env3[pre_a] <= pre_d; vld3[pre_a] <= 1'b1; end
    if (mem_en) begin
      if (mem_we) begin env1[mem_addr[7:0]] <= mem_wdata; vld1[mem_addr[7:0]] <= 1'b1; end
      ea1 <= mem_addr[7:0];
      ec1 <= 1;
    end else if (ec1 != 0 && ec1 < int'(LAT1)) ec1 <= ec1 + 1;
    else ec1 <= 0;
    if (mem_en3) begin
      if (mem_we3) begin env3[mem_addr3[7:0]] <= mem_wdata3; vld3[mem_addr3[7:0]] <= 1'b1; end
      ea3 <= mem_addr3[7:0];
      ec3 <= 1;
    end else if (ec3 != 0 && ec3 < int'(LAT3)) ec3 <= ec3 + 1;
    else ec3 <= 0;
  end

  assign mem_rdata  = (ec1 == int'(LAT1)) ? (vld1[ea1] ? env1[ea1] : fill(ea1)) : junk;
  assign mem_rdata3 = (ec3 == int'(LAT3)) ? (vld3[ea3] ? env3[ea3] : fill(ea3)) : junk;

  // Reference memory seen by the model.
  logic [15:0]  ref_mem [256];
  logic [255:0] ref_vld = '0;

  function automatic logic [15:0] ref_rd(input logic [7:0] a);
    return ref_vld[a] ? ref_mem[a] : fill(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input bit which3, input logic [15:0] a, input logic [15:0] d);
    pre_a = a[7:0];
    pre_d = d;
    if (which3) pre3 = 1'b1;
    else        pre1 = 1'b1;
    tick();
    pre1 = 1'b0;
    pre3 = 1'b0;
    if (!which3) begin ref_mem[a[7:0]] = d; ref_vld[a[7:0]] = 1'b1; end
  endtask

  task automatic rnd_txn(output logic we, output logic [15:0] a, output logic [15:0] d);
    we = 1'($urandom);
    a  = 16'($urandom_range(0, 15));
    d  = 16'($urandom);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({mem_en, mem_we, cpu_done, acc_done, busy, cpu_stall} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000000", {mem_en, mem_we, cpu_done, acc_done, busy, cpu_stall});
    end
    checks++;
    if ({mem_addr, mem_wdata, cpu_rdata, acc_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, cpu_rdata, acc_rdata});
    end
    checks++;
    if ({mem_en3, mem_we3, cpu_done3, acc_done3, busy3, cpu_stall3} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl3 got %b exp 000000", {mem_en3, mem_we3, cpu_done3, acc_done3, busy3, cpu_stall3});
    end
    checks++;
    if ({mem_addr3, mem_wdata3, cpu_rdata3, acc_rdata3} !== 64'h0) begin
      errors++; $display("FAIL reset_data3 got %h exp 0", {mem_addr3, mem_wdata3, cpu_rdata3, acc_rdata3});
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, mem_en} !== 2'b00) begin
      errors++; $display("FAIL reset_release got busy/en %b exp 00", {busy, mem_en});
    end
  endtask

  task automatic test_cpu_read();
    logic [2:0] ev [5];
    ev = '{3'b001, 3'b101, 3'b001, 3'b010, 3'b000};
    preload(1'b0, 16'h0010, 16'hBEEF);
    cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 16'h5555; cpu_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) cpu_req = 1'b0;
      #1;
      checks++;
      if ({mem_en, cpu_done, cpu_stall} !== ev[k]) begin
        errors++; $display("FAIL cpu_read_ctrl cyc %0d got en/done/stall %b exp %b", k, {mem_en, cpu_done, cpu_stall}, ev[k]);
      end
      if (k == 1) begin
        checks++;
        if ({mem_we, mem_addr} !== {1'b0, 16'h0010}) begin
          errors++; $display("FAIL cpu_read_addr got we/addr %h exp 0010", {mem_we, mem_addr});
        end
      end
      if (k == 3) begin
        checks++;
        if (cpu_rdata !== 16'hBEEF) begin
          errors++; $display("FAIL cpu_read_data got %h exp beef", cpu_rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_acc_write();
    logic [2:0] ev [5];
    ev = '{3'b000, 3'b100, 3'b000, 3'b010, 3'b000};
    acc_we = 1'b1; acc_addr = 16'h0200; acc_wdata = 16'h1234; acc_req = 1'b1;
    ref_mem[8'h00] = 16'h1234; ref_vld[8'h00] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) acc_req = 1'b0;
      #1;
      checks++;
      if ({mem_en, acc_done, cpu_done} !== ev[k]) begin
        errors++; $display("FAIL acc_write_ctrl cyc %0d got en/adone/cdone %b exp %b", k, {mem_en, acc_done, cpu_done}, ev[k]);
      end
      if (k == 1) begin
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0200, 16'h1234}) begin
          errors++; $display("FAIL acc_write_bus got %h exp 1_0200_1234", {mem_we, mem_addr, mem_wdata});
        end
      end
      if (k == 3) begin
        checks++;
        if (acc_rdata !== 16'h0000) begin
          errors++; $display("FAIL acc_write_rdata got %h exp 0000", acc_rdata);
        end
      end
      tick();
    end
    acc_we = 1'b0;
  endtask

  task automatic test_both();
    logic [2:0] ev [9];
    ev = '{3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
    cpu_we = 1'b0; cpu_addr = 16'h0010; acc_we = 1'b0; acc_addr = 16'h0200;
    cpu_req = 1'b1; acc_req = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k == 4) cpu_req = 1'b0;
      if (k == 8) acc_req = 1'b0;
      #1;
      checks++;
      if ({mem_en, cpu_done, acc_done} !== ev[k]) begin
        errors++; $display("FAIL both_ctrl cyc %0d got en/cdone/adone %b exp %b", k, {mem_en, cpu_done, acc_done}, ev[k]);
      end
      if (k == 3) begin
        checks++;
        if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL both_cpu_data got %h exp beef", cpu_rdata); end
      end
      if (k == 5) begin
        checks++;
        if ({mem_we, mem_addr} !== {1'b0, 16'h0200}) begin
          errors++; $display("FAIL both_acc_addr got %h exp 0200", {mem_we, mem_addr});
        end
      end
      if (k == 7) begin
        checks++;
        if (acc_rdata !== 16'h1234) begin errors++; $display("FAIL both_acc_data got %h exp 1234", acc_rdata); end
      end
      tick();
    end
  endtask

  task automatic test_starve();
    int ncpu = 0;
    int nacc = 0;
    cpu_we = 1'b0; cpu_addr = 16'h0010; acc_we = 1'b0; acc_addr = 16'h0200;
    cpu_req = 1'b1; acc_req = 1'b1;
    for (int k = 0; k < 120 && nacc < 2; k++) begin
      #1;
      checks++;
      if (cpu_done && acc_done) begin
        errors++; $display("FAIL starve_overlap cyc %0d got both done exp one", k);
      end
      if (cpu_done) ncpu++;
      if (acc_done) begin
        checks++;
        if (ncpu != int'(SMAX)) begin
          errors++; $display("FAIL starve_run %0d got %0d cpu grants exp %0d", nacc, ncpu, SMAX);
        end
        ncpu = 0;
        nacc++;
      end
      tick();
    end
    checks++;
    if (nacc != 2) begin errors++; $display("FAIL starve_timeout got %0d acc grants exp 2", nacc); end
    cpu_req = 1'b0; acc_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_lat3();
    logic [1:0] ev [7];
    ev = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    preload(1'b1, 16'h0040, 16'hCAFE);
    c3_we = 1'b0; c3_addr = 16'h0040; c3_wdata = 16'h0; c3_req = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 6) c3_req = 1'b0;
      #1;
      checks++;
      if ({mem_en3, cpu_done3} !== ev[k]) begin
        errors++; $display("FAIL lat3_ctrl cyc %0d got en/done %b exp %b", k, {mem_en3, cpu_done3}, ev[k]);
      end
      if (k == 5) begin
        checks++;
        if (cpu_rdata3 !== 16'hCAFE) begin errors++; $display("FAIL lat3_data got %h exp cafe", cpu_rdata3); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_req = 1'b1;
    tick();
    rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    checks++;
    if ({mem_en, mem_we, cpu_done, acc_done, busy, cpu_stall} !== 6'b0) begin
      errors++; $display("FAIL rstmid_ctrl got %b exp 000000", {mem_en, mem_we, cpu_done, acc_done, busy, cpu_stall});
    end
    checks++;
    if ({mem_addr, cpu_rdata} !== 32'h0) begin
      errors++; $display("FAIL rstmid_data got %h exp 0", {mem_addr, cpu_rdata});
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if ({mem_en, cpu_done, acc_done} !== 3'b000) begin
        errors++; $display("FAIL rstmid_quiet cyc %0d got %b exp 000", k, {mem_en, cpu_done, acc_done});
      end
      tick();
    end
    test_cpu_read();
  endtask

  task automatic test_random();
    bit          m_busy = 1'b0, m_port = 1'b0, m_we = 1'b0, cfin = 1'b0, afin = 1'b0;
    int          m_grant = -10, m_done = -10, starve = 0;
    logic [15:0] m_addr = '0, m_wdata = '0, m_rd = '0, e_crd = '0, e_ard = '0;
    logic        exp_cd, exp_ad, exp_en, exp_busy;
    cpu_req = 1'b0; acc_req = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 600; c++) begin
      if (cfin) begin
        if ($urandom_range(0, 1) == 1) rnd_txn(cpu_we, cpu_addr, cpu_wdata);
        else cpu_req = 1'b0;
        cfin = 1'b0;
      end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
        rnd_txn(cpu_we, cpu_addr, cpu_wdata);
        cpu_req = 1'b1;
      end
      if (afin) begin
        if ($urandom_range(0, 1) == 1) rnd_txn(acc_we, acc_addr, acc_wdata);
        else acc_req = 1'b0;
        afin = 1'b0;
      end else if (!acc_req && $urandom_range(0, 2) == 0) begin
        rnd_txn(acc_we, acc_addr, acc_wdata);
        acc_req = 1'b1;
      end
      if (m_busy && c > m_done) m_busy = 1'b0;
      if (!m_busy && (cpu_req || acc_req)) begin
        m_port = acc_req && (!cpu_req || starve == int'(SMAX));
        if (m_port) starve = 0;
        else if (acc_req && starve < int'(SMAX)) starve++;
        m_we    = m_port ? acc_we    : cpu_we;
        m_addr  = m_port ? acc_addr  : cpu_addr;
        m_wdata = m_port ? acc_wdata : cpu_wdata;
        if (m_we) begin ref_mem[m_addr[7:0]] = m_wdata; ref_vld[m_addr[7:0]] = 1'b1; end
        else m_rd = ref_rd(m_addr[7:0]);
        m_grant = c;
        m_done  = c + int'(LAT1) + 2;
        m_busy  = 1'b1;
      end
      exp_cd   = m_busy && c == m_done && !m_port;
      exp_ad   = m_busy && c == m_done && m_port;
      exp_en   = m_busy && c == m_grant + 1;
      exp_busy = m_busy && c > m_grant;
      if (exp_cd && !m_we) e_crd = m_rd;
      if (exp_ad && !m_we) e_ard = m_rd;
      #1;
      checks++;
      if ({mem_en, cpu_done, acc_done, busy, cpu_stall} !== {exp_en, exp_cd, exp_ad, exp_busy, cpu_req & ~exp_cd}) begin
        errors++; $display("FAIL rand_ctrl cyc %0d got en/cd/ad/busy/stall %b exp %b", c,
                           {mem_en, cpu_done, acc_done, busy, cpu_stall}, {exp_en, exp_cd, exp_ad, exp_busy, cpu_req & ~exp_cd});
      end
      checks++;
      if ({cpu_rdata, acc_rdata} !== {e_crd, e_ard}) begin
        errors++; $display("FAIL rand_rdata cyc %0d got %h exp %h", c, {cpu_rdata, acc_rdata}, {e_crd, e_ard});
      end
      if (exp_en) begin
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {m_we, m_addr, m_wdata}) begin
          errors++; $display("FAIL rand_bus cyc %0d got %h exp %h", c, {mem_we, mem_addr, mem_wdata}, {m_we, m_addr, m_wdata});
        end
      end
      if (exp_cd) cfin = 1'b1;
      if (exp_ad) afin = 1'b1;
      tick();
    end
    cpu_req = 1'b0; acc_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    acc_req = 1'b0; acc_we = 1'b0; acc_addr = '0; acc_wdata = '0;
    c3_req = 1'b0; c3_we = 1'b0; c3_addr = '0; c3_wdata = '0;
    test_reset();
    test_cpu_read();
    test_acc_write();
    test_both();
    test_starve();
    test_lat3();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
